uart_tx_gen2: RTL and testbench
===============================

UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning transmit FIFO depth in words (power of two, >=2).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of baud divisor.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port uart_en  input  1  block enable.
REQ-006 SHALL have port baud_div  input  DIV_W  bit period = baud_div+1 clocks.
REQ-007 SHALL have port data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 SHALL have port parity_mode  input  2  00/11=none, 01=even, 10=odd.
REQ-009 SHALL have port stop2  input  1  0=one stop bit, 1=two stop bits.
REQ-010 SHALL have port tx_valid  input  1  write request.
REQ-011 SHALL have port tx_data  input  8  write data, LSB sent first.
REQ-012 SHALL have port tx_ready  output  1  FIFO can accept a word.
REQ-013 SHALL have port fifo_count  output  $clog2(DEPTH)+1  words held in FIFO.
REQ-014 SHALL have port busy  output  1  frame in progress (state != IDLE).
REQ-015 SHALL have port TX  output  1  registered serial line, idle high.
REQ-016 SHALL have port tx_done  output  1  one-cycle pulse, end of frame.

Function
REQ-017 SHALL assert tx_ready = uart_en && (fifo_count < DEPTH); word written on an edge where tx_valid && tx_ready; words with tx_ready low are dropped.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when parity_mode is none.
REQ-019 SHALL, in IDLE with uart_en=1 and fifo_count>0, pop the head word on that edge, latch baud_div/data_bits/parity_mode/stop2, enter START and drive TX<=0 on the same edge.
REQ-020 SHALL hold every bit (start, each data, parity, each stop) on TX for exactly baud_div+1 clocks; baud_div=0 gives one-clock bits.
REQ-021 SHALL send data bits LSB first, count = latched data_bits; upper unused bits of tx_data ignored.
REQ-022 SHALL send parity bit = XOR of sent data bits (even) or its inverse (odd).
REQ-023 SHALL send one or two stop bits (TX=1) per latched stop2.
REQ-024 SHALL pulse tx_done in the last clock of the final stop bit; if FIFO non-empty, next START begins on the following edge (no idle gap); else return to IDLE with TX=1.
REQ-025 SHALL permit simultaneous push and pop on one edge; fifo_count unchanged in that case; FIFO pointers wrap modulo DEPTH.
REQ-026 SHALL leave configuration changes during a frame without effect until the next frame start.
REQ-027 SHALL, when uart_en falls mid-frame, abort on the next edge: state IDLE, TX<=1, no tx_done, aborted word lost, remaining FIFO contents retained.
REQ-028 SHALL not pop or start a frame while uart_en=0.

Reset
REQ-029 SHALL, on resetn=0 at a rising edge, set state IDLE, TX=1, tx_done=0, busy=0, FIFO empty (fifo_count=0), bit/baud counters 0; tx_ready=0 during reset.
REQ-030 SHALL apply reset mid-frame identically, truncating the frame with TX returning high on that edge.

Verification
REQ-031 SHALL check 8N1, baud_div=3, 0xA5: TX low 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, stop 4 clk; tx_done at clock 40 of frame.
REQ-032 SHALL check 7E2, baud_div=1, 0x41: frame 11 bits x2 clk, data 1,0,0,0,0,0,1, parity 0, two stop bits high.
REQ-033 SHALL check 8O1 0x00 -> parity bit 1; 5N1 0xFF -> only five 1 bits then stop.
REQ-034 SHALL check DEPTH=4, baud_div=3, six back-to-back writes: five accepted (first popped immediately), tx_ready low at sixth until a pop; five frames back-to-back, TX never idles between them.
REQ-035 SHALL check uart_en dropped mid-DATA: TX=1 next clock, no tx_done, fifo_count unchanged; re-enable resumes with next FIFO word.
REQ-036 SHALL check resetn pulsed mid-frame: TX=1, fifo_count=0, busy=0 after the reset edge.

Source files
------------

// File: rtl/uart_tx_gen2.sv
// UART transmitter: small word FIFO feeding a serializer with runtime frame
// format (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and baud divisor.
module uart_tx_gen2 #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   uart_en,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [1:0]             data_bits,
  input  logic [1:0]             parity_mode,
  input  logic                   stop2,
  input  logic                   tx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   TX,
  output logic                   tx_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  state_t           state_reg;
  logic [DIV_W-1:0] baud_cnt_reg;
  logic [DIV_W-1:0] baud_next;
  logic [DIV_W-1:0] div_reg;
  logic [2:0]       bit_cnt_reg;
  logic [2:0]       last_bit;
  logic             stop_cnt_reg;
  logic [7:0]       shift_reg;
  logic             par_reg;
  logic [1:0]       bits_reg;
  logic [1:0]       parity_reg;
  logic             stop2_reg;

  logic push;
  logic pop;
  logic bit_end;
  logic stop_last;
  logic frame_end;

  assign tx_ready   = resetn && uart_en && (count_reg < DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt_reg == div_reg);
  assign baud_next  = baud_cnt_reg + DIV_W'(1);
  assign stop_last  = (stop_cnt_reg == stop2_reg);
  assign frame_end  = (state_reg == STOP) && bit_end && stop_last;
  // A new frame starts either from IDLE or directly out of the final stop bit.
  assign pop        = uart_en && (count_reg != '0) && ((state_reg == IDLE) || frame_end);
  assign last_bit   = {1'b0, bits_reg} + 3'd4;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      TX           <= 1'b1;
      tx_done      <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      div_reg      <= '0;
      bits_reg     <= '0;
      parity_reg   <= '0;
      stop2_reg    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if ((state_reg != IDLE) && !uart_en) begin
        state_reg    <= IDLE;
        TX           <= 1'b1;
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
      end else if (pop) begin
        state_reg    <= START;
        TX           <= 1'b0;
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
        stop_cnt_reg <= 1'b0;
        par_reg      <= 1'b0;
        shift_reg    <= mem[rd_ptr_reg];
        div_reg      <= baud_div;
        bits_reg     <= data_bits;
        parity_reg   <= parity_mode;
        stop2_reg    <= stop2;
      end else begin
        case (state_reg)
          IDLE: begin
            TX <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state_reg    <= DATA;
              baud_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              TX           <= shift_reg[0];
              par_reg      <= shift_reg[0];
              shift_reg    <= shift_reg >> 1;
            end else begin
              baud_cnt_reg <= baud_next;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt_reg <= '0;
              if (bit_cnt_reg == last_bit) begin
                if (^parity_reg) begin
                  state_reg <= PARITY;
                  TX        <= par_reg ^ parity_reg[1];
                end else begin
                  state_reg    <= STOP;
                  TX           <= 1'b1;
                  stop_cnt_reg <= 1'b0;
                  tx_done      <= (div_reg == '0) && !stop2_reg;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                TX          <= shift_reg[0];
                par_reg     <= par_reg ^ shift_reg[0];
                shift_reg   <= shift_reg >> 1;
              end
            end else begin
              baud_cnt_reg <= baud_next;
            end
          end
          PARITY: begin
            if (bit_end) begin
              state_reg    <= STOP;
              baud_cnt_reg <= '0;
              TX           <= 1'b1;
              stop_cnt_reg <= 1'b0;
              tx_done      <= (div_reg == '0) && !stop2_reg;
            end else begin
              baud_cnt_reg <= baud_next;
            end
          end
          STOP: begin
            // tx_done is registered one edge early so it lands in the final clock.
            if (bit_end) begin
              baud_cnt_reg <= '0;
              if (!stop_last) begin
                stop_cnt_reg <= 1'b1;
                tx_done      <= (div_reg == '0);
              end else begin
                state_reg <= IDLE;
                TX        <= 1'b1;
              end
            end else begin
              baud_cnt_reg <= baud_next;
              tx_done      <= stop_last && (baud_next == div_reg);
            end
          end
          default: begin
            state_reg <= IDLE;
            TX        <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Scoreboard bench for uart_tx_gen2: stimulus queues hand-written frame
// bit strings, a monitor samples TX on falling edges and compares.
`timescale 1ns/1ps
module tb_uart_tx_gen2;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic                   clock = 1'b0;
  logic                   resetn = 1'b0;
  logic                   uart_en = 1'b0;
  logic [DIV_W-1:0]       baud_div = '0;
  logic [1:0]             data_bits = 2'b11;
  logic [1:0]             parity_mode = 2'b00;
  logic                   stop2 = 1'b0;
  logic                   tx_valid = 1'b0;
  logic [7:0]             tx_data = 8'h00;
  logic                   tx_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   busy;
  logic                   TX;
  logic                   tx_done;

  always #5 clock = ~clock;

  uart_tx_gen2 #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clock(clock), .resetn(resetn), .uart_en(uart_en), .baud_div(baud_div),
    .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .busy(busy), .TX(TX), .tx_done(tx_done)
  );

  typedef struct packed {
    logic [11:0] bits;
    logic [3:0]  nbits;
    logic [15:0] div;
    logic [7:0]  abort_clk;
    logic        b2b;
  } frame_t;

  frame_t     exp_q[$];
  int         checks = 0;
  int         passes = 0;
  bit         mon_active = 1'b0;
  frame_t     cur;
  int         gap, nf, bit_len, total;
  logic [11:0] bad;
  bit         done_ok;
  bit         acc;
  logic [7:0] b2b_words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  bit         b2b_acc   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Bit string is in transmission order: start, data LSB first, parity, stops.
  function automatic void expect_frame(input string s, input int div, input int abort_clk, input bit b2b);
    frame_t f;
    f = '0;
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s[i] == 8'h31);
    f.nbits     = 4'(s.len());
    f.div       = 16'(div);
    f.abort_clk = 8'(abort_clk);
    f.b2b       = b2b;
    exp_q.push_back(f);
  endfunction

  task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] pm, input logic s2);
    baud_div = DIV_W'(div);
    data_bits = db;
    parity_mode = pm;
    stop2 = s2;
  endtask

  task automatic write_word(input logic [7:0] d, output bit accepted);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data = d;
    #1;
    accepted = tx_ready;
  endtask

  task automatic end_write();
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_busy_seen"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy !== 1'b0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  initial begin : monitor
    gap = 0;
    nf = 0;
    forever begin
      @(negedge clock);
      while (TX === 1'b0 && resetn === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_TX", TX, 32'd1);
          while (TX === 1'b0) @(negedge clock);
        end else begin
          cur = exp_q.pop_front();
          mon_active = 1'b1;
          bit_len = int'(cur.div) + 1;
          if (cur.b2b) check($sformatf("frame%0d_idle_gap", nf), gap, 32'd0);
          total = (cur.abort_clk != 0) ? int'(cur.abort_clk) : int'(cur.nbits) * bit_len;
          bad = '0;
          done_ok = 1'b1;
          for (int k = 0; k < total; k++) begin
            if (TX !== cur.bits[k / bit_len]) bad[k / bit_len] = 1'b1;
            if (tx_done !== ((cur.abort_clk == 0) && (k == total - 1))) done_ok = 1'b0;
            @(negedge clock);
          end
          for (int i = 0; i <= (total - 1) / bit_len; i++)
            check($sformatf("frame%0d_bit%0d_wrong", nf, i), 32'(bad[i]), 32'd0);
          check($sformatf("frame%0d_tx_done_timing", nf), 32'(done_ok), 32'd1);
          if (cur.abort_clk != 0) begin
            check($sformatf("frame%0d_abort_TX", nf), TX, 32'd1);
            check($sformatf("frame%0d_abort_tx_done", nf), tx_done, 32'd0);
          end
          $display("frame %0d: %0d bits, div %0d, %0d clocks checked%s",
                   nf, cur.nbits, cur.div, total, (cur.abort_clk != 0) ? ", aborted" : "");
          nf++;
          gap = 0;
          mon_active = 1'b0;
        end
      end
      gap++;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    uart_en = 1'b1;
    set_cfg(3, 2'b11, 2'b00, 1'b0);
    repeat (3) @(negedge clock);
    check("rst_TX", TX, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_tx_done", tx_done, 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_tx_ready", tx_ready, 32'd0);
    resetn = 1'b1;
    #1;
    check("ready_after_reset", tx_ready, 32'd1);

    // 8N1 div 3, 0xA5: 40-clock frame
    expect_frame("0101001011", 3, 0, 1'b0);
    write_word(8'hA5, acc);
    check("t1_accept", 32'(acc), 32'd1);
    end_write();
    wait_drain("t1", 200);

    // 7E2 div 1, 0x41; config scrambled mid-frame must not matter
    set_cfg(1, 2'b10, 2'b01, 1'b1);
    expect_frame("01000001011", 1, 0, 1'b0);
    write_word(8'h41, acc);
    end_write();
    wait_busy("t2", 20);
    set_cfg(3, 2'b11, 2'b10, 1'b0);
    wait_drain("t2", 200);

    // 8O1 div 2, 0x00 -> parity 1
    set_cfg(2, 2'b11, 2'b10, 1'b0);
    expect_frame("00000000011", 2, 0, 1'b0);
    write_word(8'h00, acc);
    end_write();
    wait_drain("t3", 200);

    // 5N1 (parity code 11) div 0, 0xFF: one-clock bits
    set_cfg(0, 2'b00, 2'b11, 1'b0);
    expect_frame("0111111", 0, 0, 1'b0);
    write_word(8'hFF, acc);
    end_write();
    wait_drain("t4", 100);

    // 6E1 div 1, 0x2D
    set_cfg(1, 2'b01, 2'b01, 1'b0);
    expect_frame("010110101", 1, 0, 1'b0);
    write_word(8'h2D, acc);
    end_write();
    wait_drain("t5", 100);

    // Six back-to-back writes into a depth-4 FIFO
    set_cfg(3, 2'b11, 2'b00, 1'b0);
    expect_frame("0100010001", 3, 0, 1'b0);
    expect_frame("0010001001", 3, 0, 1'b1);
    expect_frame("0110011001", 3, 0, 1'b1);
    expect_frame("0001000101", 3, 0, 1'b1);
    expect_frame("0101010101", 3, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      write_word(b2b_words[i], acc);
      check($sformatf("b2b_accept%0d", i), 32'(acc), 32'(b2b_acc[i]));
    end
    end_write();
    check("b2b_full_count", 32'(fifo_count), 32'd4);
    check("b2b_full_ready", tx_ready, 32'd0);
    begin
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("b2b_ready_returns", 32'(n < 100), 32'd1);
      check("b2b_count_after_pop", 32'(fifo_count), 32'd3);
    end
    wait_drain("t6", 400);

    // uart_en dropped mid-DATA at frame clock 10
    expect_frame("0110000111", 3, 11, 1'b0);
    expect_frame("0010110101", 3, 0, 1'b0);
    expect_frame("0111100001", 3, 0, 1'b1);
    write_word(8'hC3, acc);
    end_write();
    wait_busy("t7", 20);
    write_word(8'h5A, acc);
    write_word(8'h0F, acc);
    end_write();
    repeat (7) @(negedge clock);
    uart_en = 1'b0;
    @(negedge clock);
    check("abort_TX", TX, 32'd1);
    check("abort_busy", busy, 32'd0);
    check("abort_fifo_count", 32'(fifo_count), 32'd2);
    repeat (10) @(negedge clock);
    check("disabled_no_pop", 32'(fifo_count), 32'd2);
    check("disabled_idle", busy, 32'd0);
    uart_en = 1'b1;
    wait_drain("t7", 300);

    // resetn pulsed at frame clock 6
    expect_frame("0100110011", 3, 7, 1'b0);
    write_word(8'h99, acc);
    end_write();
    wait_busy("t8", 20);
    write_word(8'h77, acc);
    end_write();
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("midreset_TX", TX, 32'd1);
    check("midreset_fifo_count", 32'(fifo_count), 32'd0);
    check("midreset_busy", busy, 32'd0);
    check("midreset_tx_ready", tx_ready, 32'd0);
    resetn = 1'b1;
    repeat (60) @(negedge clock);
    check("post_reset_idle_busy", busy, 32'd0);
    check("post_reset_idle_TX", TX, 32'd1);
    check("post_reset_count", 32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
